// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: word width, reset/NOP constants,
// fetch-queue types and small PC helpers used by every stage.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0040_0000;
    localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013; // addi x0,x0,0

    // Occupancy of the 2-entry fetch queue
    typedef enum logic [1:0] {
        Q_EMPTY = 2'd0,
        Q_ONE   = 2'd1,
        Q_FULL  = 2'd2
    } fq_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fq_entry_t;

    // Sequential fetch address; wraps modulo 2^XLEN
    function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

    // Instructions are word aligned, so the low two target bits are dropped
    function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry {instruction, pc} queue between instruction memory and decode.
// Head entry is always the oldest; flush empties it in one cycle.
module fetch_queue
    import riscv_pkg::*;
(
    input  logic      clk,
    input  logic      rst_ni,
    input  logic      flush_i,
    input  logic      push_i,
    input  fq_entry_t push_data_i,
    input  logic      pop_i,
    output fq_entry_t head_o,
    output logic      full_o,
    output logic      empty_o
);

    fq_state_e state_q;
    logic      empty_q;
    logic      full_q;
    fq_entry_t head_q, head_d;
    fq_entry_t tail_q, tail_d;

    // Occupancy FSM; a simultaneous push and pop keeps the current state
    always_ff @(posedge clk) begin
        if (!rst_ni || flush_i) begin
            state_q <= Q_EMPTY;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            case (state_q)
                Q_EMPTY: begin
                    if (push_i) begin
                        state_q <= Q_ONE;
                        empty_q <= 1'b0;
                    end
                end
                Q_ONE: begin
                    if (push_i && !pop_i) begin
                        state_q <= Q_FULL;
                        full_q  <= 1'b1;
                    end else if (pop_i && !push_i) begin
                        state_q <= Q_EMPTY;
                        empty_q <= 1'b1;
                    end
                end
                Q_FULL: begin
                    if (pop_i && !push_i) begin
                        state_q <= Q_ONE;
                        full_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= Q_EMPTY;
                    empty_q <= 1'b1;
                    full_q  <= 1'b0;
                end
            endcase
        end
    end

    // Entry steering: new data lands in head when head is free after this edge, else in tail
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (state_q == Q_FULL && pop_i) begin
            head_d = tail_q;
        end
        if (push_i) begin
            if (state_q == Q_EMPTY || (state_q == Q_ONE && pop_i)) begin
                head_d = push_data_i;
            end else begin
                tail_d = push_data_i;
            end
        end
    end

    // Payload registers carry no reset; occupancy alone decides what is valid
    always_ff @(posedge clk) begin
        head_q <= head_d;
        tail_q <= tail_d;
    end

    assign head_o  = head_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;

    // Issue throttling upstream must never let a push overflow a full queue
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_ni || flush_i)
        !(push_i && !pop_i && full_q));

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_ni || flush_i)
        !(pop_i && empty_q));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: fetch PC, issue throttling against a 2-entry
// queue, single-outstanding memory request and redirect/flush handling.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] imem_addr,
    output logic            imem_req,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            hold,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] instruction_out,
    output logic [XLEN-1:0] pc_out,
    output logic            valid_out,
    output logic            IF_flush
);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            inflight_q, inflight_d;
    logic [XLEN-1:0] issued_pc_q, issued_pc_d;

    fq_entry_t       head;
    fq_entry_t       push_data;
    logic            q_full;
    logic            q_empty;
    logic [1:0]      occupancy;
    logic [2:0]      demand;
    logic            deq;
    logic            issue;
    logic            enq;

    // Reset gates the visible outputs so nothing stale leaks during reset
    assign valid_out       = reset & ~q_empty;
    assign instruction_out = valid_out ? head.instr : NOP_INSTR;
    assign pc_out          = valid_out ? head.pc : '0;
    assign IF_flush        = redirect;

    assign deq       = valid_out & ~hold;
    assign occupancy = q_full ? 2'd2 : (q_empty ? 2'd0 : 2'd1);
    assign demand    = {1'b0, occupancy} + {2'b00, inflight_q};
    // Only issue when queued + outstanding work, net of this cycle's dequeue, leaves room
    assign issue     = reset & ~redirect & (demand < (3'd2 + {2'b00, deq}));
    assign enq       = reset & inflight_q & ~redirect;

    assign imem_req  = issue;
    assign imem_addr = fetch_pc_q;

    assign push_data.instr = imem_rdata;
    assign push_data.pc    = issued_pc_q;

    // Next fetch PC and outstanding-request flag; redirect discards the response in flight
    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        inflight_d  = inflight_q;
        issued_pc_d = issued_pc_q;
        if (redirect) begin
            fetch_pc_d = pc_align(redirect_pc);
            inflight_d = 1'b0;
        end else begin
            inflight_d = issue;
            if (issue) begin
                fetch_pc_d  = pc_next(fetch_pc_q);
                issued_pc_d = fetch_pc_q;
            end
        end
    end

    // Control state with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            inflight_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
        end
    end

    // PC of the outstanding request, paired with its response on enqueue
    always_ff @(posedge clk) begin
        issued_pc_q <= issued_pc_d;
    end

    fetch_queue u_queue (
        .clk         (clk),
        .rst_ni      (reset),
        .flush_i     (redirect),
        .push_i      (enq),
        .push_data_i (push_data),
        .pop_i       (deq & ~redirect),
        .head_o      (head),
        .full_o      (q_full),
        .empty_o     (q_empty)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a queue-based reference model and
// hand-computed pins on the key sequences.
module tb_fetch_unit;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] RPC  = 32'h0040_0000;
    localparam logic [31:0] IDLE = 32'hDEAD_BEEF;

    logic        clk;
    logic        reset;
    logic        hold;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_rdata;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] instruction_out;
    logic [31:0] pc_out;
    logic        valid_out;
    logic        IF_flush;

    fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .imem_addr       (imem_addr),
        .imem_req        (imem_req),
        .imem_rdata      (imem_rdata),
        .hold            (hold),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .instruction_out (instruction_out),
        .pc_out          (pc_out),
        .valid_out       (valid_out),
        .IF_flush        (IF_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    // Reference model: instructions waiting for decode, plus the one request in flight
    ent_t        mq[$];
    bit          m_inf;
    logic [31:0] m_inf_pc;
    logic [31:0] m_fpc;
    logic [31:0] rsp_next;

    logic        s_valid, s_req, s_flush;
    logic [31:0] s_instr, s_pc, s_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    // One clock: drive inputs, compare against the model, advance the model
    task automatic step(input logic rst_v, input logic hold_v, input logic redir_v,
                        input logic [31:0] rpc_v);
        int          occ;
        bit          e_valid, e_req, e_deq;
        logic [31:0] e_instr, e_pc;
        @(negedge clk);
        reset       = rst_v;
        hold        = hold_v;
        redirect    = redir_v;
        redirect_pc = rpc_v;
        imem_rdata  = rsp_next;
        #2;
        occ     = mq.size();
        e_valid = rst_v && (occ > 0);
        e_instr = e_valid ? mq[0].instr : NOP;
        e_pc    = e_valid ? mq[0].pc : 32'h0;
        e_deq   = e_valid && !hold_v;
        e_req   = rst_v && !redir_v && ((occ + int'(m_inf) - int'(e_deq)) < 2);

        s_valid = valid_out;
        s_req   = imem_req;
        s_flush = IF_flush;
        s_instr = instruction_out;
        s_pc    = pc_out;
        s_addr  = imem_addr;

        check("valid_out", {31'b0, s_valid}, {31'b0, e_valid});
        check("instruction_out", s_instr, e_instr);
        check("pc_out", s_pc, e_pc);
        check("IF_flush", {31'b0, s_flush}, {31'b0, redir_v});
        check("imem_req", {31'b0, s_req}, {31'b0, e_req});
        if (e_req) check("imem_addr", s_addr, m_fpc);

        // Instruction memory: answers the cycle after a request
        rsp_next = s_req ? (32'h1000_0000 | s_addr) : IDLE;

        @(posedge clk);
        if (!rst_v) begin
            mq.delete();
            m_inf = 1'b0;
            m_fpc = RPC;
        end else if (redir_v) begin
            mq.delete();
            m_inf = 1'b0;
            m_fpc = rpc_v & 32'hFFFF_FFFC;
        end else begin
            if (e_deq) void'(mq.pop_front());
            if (m_inf) mq.push_back('{instr: 32'h1000_0000 | m_inf_pc, pc: m_inf_pc});
            if (e_req) begin
                m_inf_pc = m_fpc;
                m_fpc    = m_fpc + 32'd4;
            end
            m_inf = e_req;
        end
        cyc++;
    endtask

    initial begin
        reset       = 1'b0;
        hold        = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_rdata  = 32'h0;
        rsp_next    = IDLE;
        m_inf       = 1'b0;
        m_inf_pc    = 32'h0;
        m_fpc       = RPC;

        // Reset cycles
        step(0, 0, 0, 32'h0);
        check("rst_valid", {31'b0, s_valid}, 32'd0);
        check("rst_instr", s_instr, 32'h0000_0013);
        check("rst_pc", s_pc, 32'h0);
        check("rst_req", {31'b0, s_req}, 32'd0);
        step(0, 0, 0, 32'h0);

        // Startup streaming with hold low
        step(1, 0, 0, 32'h0);
        check("start_req0", {31'b0, s_req}, 32'd1);
        check("start_addr0", s_addr, 32'h0040_0000);
        step(1, 0, 0, 32'h0);
        check("start_valid1", {31'b0, s_valid}, 32'd0);
        check("start_instr1", s_instr, 32'h0000_0013);
        check("start_addr1", s_addr, 32'h0040_0004);
        step(1, 0, 0, 32'h0);
        check("start_valid2", {31'b0, s_valid}, 32'd1);
        check("start_pc2", s_pc, 32'h0040_0000);
        check("start_instr2", s_instr, 32'h1040_0000);
        check("start_addr2", s_addr, 32'h0040_0008);
        step(1, 0, 0, 32'h0);
        check("start_pc3", s_pc, 32'h0040_0004);
        repeat (3) step(1, 0, 0, 32'h0);

        // Fresh start under hold: queue fills, issue stops
        step(0, 0, 0, 32'h0);
        for (int i = 0; i < 7; i++) begin
            step(1, 1, 0, 32'h0);
            if (i == 4) begin
                check("hold_full_req", {31'b0, s_req}, 32'd0);
                check("hold_full_valid", {31'b0, s_valid}, 32'd1);
                check("hold_full_pc", s_pc, 32'h0040_0000);
            end
        end
        step(1, 0, 0, 32'h0);
        check("release_pc0", s_pc, 32'h0040_0000);
        step(1, 0, 0, 32'h0);
        check("release_pc1", s_pc, 32'h0040_0004);
        step(1, 0, 0, 32'h0);
        check("release_pc2", s_pc, 32'h0040_0008);
        step(1, 0, 0, 32'h0);

        // Redirect to a misaligned target while streaming
        step(1, 0, 1, 32'h0040_0103);
        check("redir_flush", {31'b0, s_flush}, 32'd1);
        check("redir_req", {31'b0, s_req}, 32'd0);
        step(1, 0, 0, 32'h0);
        check("redir_valid1", {31'b0, s_valid}, 32'd0);
        check("redir_addr1", s_addr, 32'h0040_0100);
        step(1, 0, 0, 32'h0);
        check("redir_valid2", {31'b0, s_valid}, 32'd0);
        step(1, 0, 0, 32'h0);
        check("redir_valid3", {31'b0, s_valid}, 32'd1);
        check("redir_pc3", s_pc, 32'h0040_0100);
        check("redir_instr3", s_instr, 32'h1040_0100);

        // Fill the queue, then redirect and hold together, target wraps the address space
        step(1, 1, 0, 32'h0);
        step(1, 1, 0, 32'h0);
        step(1, 1, 1, 32'hFFFF_FFFC);
        check("rh_old_head", {31'b0, s_valid}, 32'd1);
        check("rh_flush", {31'b0, s_flush}, 32'd1);
        step(1, 0, 0, 32'h0);
        check("rh_valid1", {31'b0, s_valid}, 32'd0);
        check("wrap_addr1", s_addr, 32'hFFFF_FFFC);
        step(1, 0, 0, 32'h0);
        check("wrap_addr2", s_addr, 32'h0000_0000);
        step(1, 0, 0, 32'h0);
        check("wrap_pc0", s_pc, 32'hFFFF_FFFC);
        check("wrap_instr0", s_instr, 32'hFFFF_FFFC);
        step(1, 0, 0, 32'h0);
        check("wrap_pc1", s_pc, 32'h0000_0000);
        check("wrap_instr1", s_instr, 32'h1000_0000);

        // Reset mid-stream with the queue full
        step(1, 1, 0, 32'h0);
        step(1, 1, 0, 32'h0);
        step(1, 1, 0, 32'h0);
        check("pre_rst_valid", {31'b0, s_valid}, 32'd1);
        step(0, 1, 0, 32'h0);
        check("mid_rst_valid", {31'b0, s_valid}, 32'd0);
        check("mid_rst_instr", s_instr, 32'h0000_0013);
        step(1, 0, 0, 32'h0);
        check("post_rst_valid", {31'b0, s_valid}, 32'd0);
        check("post_rst_pc", s_pc, 32'h0);
        check("post_rst_addr", s_addr, 32'h0040_0000);
        step(1, 0, 0, 32'h0);
        step(1, 0, 0, 32'h0);
        check("post_rst_first", s_pc, 32'h0040_0000);
        repeat (3) step(1, 0, 0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0040_0000, the PC loaded on reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), the instruction presented when the queue is empty.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-low reset (0 = reset, sampled on the clk rising edge).
REQ-005 SHALL have port imem_addr, output, 32, the fetch address driven to instruction memory.
REQ-006 SHALL have port imem_req, output, 1, high when a fetch is issued this cycle.
REQ-007 SHALL have port imem_rdata, input, 32, the instruction word, valid the cycle after its request.
REQ-008 SHALL have port hold, input, 1, downstream IF/ID stall (1 = do not consume).
REQ-009 SHALL have port redirect, input, 1, taken branch or jump resolved downstream.
REQ-010 SHALL have port redirect_pc, input, 32, the target address when redirect = 1.
REQ-011 SHALL have port instruction_out, output, 32, the instruction at the queue head.
REQ-012 SHALL have port pc_out, output, 32, the PC of instruction_out.
REQ-013 SHALL have port valid_out, output, 1, high when instruction_out and pc_out hold a real fetched instruction.
REQ-014 SHALL have port IF_flush, output, 1, equal to redirect in the same cycle (combinational), feeding the IF/ID register.

Function
REQ-015 SHALL keep a fetch PC register; imem_addr SHALL equal fetch PC whenever imem_req = 1.
REQ-016 SHALL keep a 2-entry {instruction, pc} queue; its occupancy states are EMPTY, ONE and FULL.
REQ-017 SHALL keep one inflight flag, set for the cycle after each issue.
REQ-018 SHALL dequeue when valid_out = 1 and hold = 0 (deq).
REQ-019 SHALL issue (imem_req = 1) when redirect = 0 and count + inflight - deq < 2.
REQ-020 On issue, SHALL update fetch PC to PC + 4, computed modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
REQ-021 When inflight = 1 and redirect = 0, SHALL enqueue {imem_rdata, issued PC} at the rising edge.
REQ-022 A simultaneous enqueue and dequeue SHALL leave the occupancy state unchanged.
REQ-023 Transitions: EMPTY->ONE on enqueue only; ONE->FULL on enqueue only; FULL->ONE on deq only; ONE->EMPTY on deq only.
REQ-024 SHALL never enqueue while FULL without a same-cycle dequeue; REQ-019 guarantees this, and an assertion SHALL check it.
REQ-025 valid_out SHALL be 1 iff the state is not EMPTY; when EMPTY, instruction_out = NOP_INSTR and pc_out = 0.
REQ-026 On redirect = 1 (priority over hold, deq and enqueue), at the next edge: queue -> EMPTY, inflight cleared (that response is discarded), fetch PC <= {redirect_pc[31:2], 2'b00}.
REQ-027 Redirect latency: redirect in cycle N; issue at the new PC in N+1; data enqueued at the end of N+2; valid_out = 1 in N+3.
REQ-028 Under sustained hold = 1, the queue SHALL fill to FULL and issue SHALL stop; no instruction is lost or duplicated.
REQ-029 With hold = 0 and no redirect, SHALL sustain one instruction per cycle after a 2-cycle startup.

Reset
REQ-030 While reset = 0 at an edge: fetch PC <= RESET_PC, queue -> EMPTY, inflight <= 0.
REQ-031 During reset and the cycle after it: valid_out = 0, imem_req = 0 in the reset cycle, instruction_out = NOP_INSTR, pc_out = 0.
REQ-032 Reset asserted mid-operation SHALL discard queue and inflight data, identically to a redirect.

Structure
REQ-033 RESET_PC default, NOP_INSTR and XLEN = 32 SHALL live in a shared package (riscv_pkg) used by all pipeline stages.
REQ-034 The queue SHALL be a sub-module fetch_queue with push, pop, flush, full and empty signals; PC and issue logic stay in fetch_unit.

Verification
REQ-035 Reset release, hold = 0, imem_rdata = 32'h1000_0000 | addr: fetches at 0x00400000, 0x00400004, 0x00400008; valid_out first high 2 cycles after release.
REQ-036 hold = 1 for 5 cycles after 1 instruction is valid: state FULL, imem_req = 0 while FULL; on release, pc_out goes 0x00400000, then 0x00400004, with no gaps or duplicates.
REQ-037 redirect = 1, redirect_pc = 32'h0040_0103 while FULL with inflight: next cycle valid_out = 0 and IF_flush = 1 in the redirect cycle; the first valid pc_out = 0x00400100, 3 cycles later.
REQ-038 redirect and hold both 1 in the same cycle: the flush takes effect; the old head is not delivered.
REQ-039 redirect_pc = 32'hFFFF_FFFC: pc_out sequence is 0xFFFFFFFC, then 0x00000000.
REQ-040 reset = 0 asserted mid-stream with the queue FULL: next cycle valid_out = 0 and instruction_out = 0x00000013; refetch restarts at 0x00400000.
